// File: rtl/ext_bus_ctrl.sv
// External-bus sequencer for the t8051 core. It arbitrates between the fetch
// and MOVX requesters, then runs one multiplexed P0/P2 bus cycle at a time:
// ADDR (ALE high), LATCH, STROBE (PSEN_n/RD_n/WR_n low), HOLD (ack).
module ext_bus_ctrl #(
  parameter int ALE_CYC = 2,
  parameter int STB_CYC = 3
) (
  input  logic        xtal2,
  input  logic        rst,
  input  logic        fetch_req,
  input  logic [15:0] fetch_addr,
  output logic        fetch_ack,
  output logic [7:0]  fetch_data,
  input  logic        data_req,
  input  logic        data_we,
  input  logic        data_wide,
  input  logic [15:0] data_addr,
  input  logic [7:0]  data_wdata,
  output logic        data_ack,
  output logic [7:0]  data_rdata,
  output logic        busy,
  input  logic [7:0]  p0_in,
  output logic [7:0]  p0_out,
  output logic        p0_oe,
  output logic [7:0]  p2_out,
  output logic        p2_oe,
  output logic        ale_o,
  output logic        psen_n,
  output logic        rd_n,
  output logic        wr_n
);

  localparam int CNT_MAX = (ALE_CYC > STB_CYC) ? ALE_CYC : STB_CYC;
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam logic [CW-1:0] ALE_LD = CW'(ALE_CYC - 1);
  localparam logic [CW-1:0] STB_LD = CW'(STB_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_LATCH, S_STROBE, S_HOLD} state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  // One-deep pending slots with their sampled fields.
  logic        f_pend;
  logic [15:0] f_addr_q;
  logic        d_pend, d_we_q, d_wide_q;
  logic [15:0] d_addr_q;
  logic [7:0]  d_wdata_q;

  // Access in service.
  logic        cur_data, cur_we;
  logic [7:0]  cur_wdata;

  // Tie-break pointer: 1 means data wins the next simultaneous request.
  logic        prio_data;

  logic        f_new, d_new, f_cand, d_cand, start, pick_data, tie;
  logic [15:0] sel_addr;
  logic        sel_we, sel_p2;
  logic [7:0]  sel_wdata;

  // Request acceptance, arbitration and the fields of the winning request.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    f_new     = fetch_req && !f_pend && !((state != S_IDLE) && !cur_data);
    d_new     = data_req  && !d_pend && !((state != S_IDLE) &&  cur_data);
    f_cand    = f_pend || f_new;
    d_cand    = d_pend || d_new;
    tie       = f_cand && d_cand;
    start     = ((state == S_IDLE) || (state == S_HOLD)) && (f_cand || d_cand);
    pick_data = d_cand && (!f_cand || prio_data);
    sel_addr  = f_pend ? f_addr_q : fetch_addr;
    sel_we    = 1'b0;
    sel_p2    = 1'b1;
    sel_wdata = 8'h00;
    if (pick_data) begin
      sel_addr  = d_pend ? d_addr_q  : data_addr;
      sel_we    = d_pend ? d_we_q    : data_we;
      sel_p2    = d_pend ? d_wide_q  : data_wide;
      sel_wdata = d_pend ? d_wdata_q : data_wdata;
    end
  end

  // Sequencer FSM with registered bus outputs and read-data capture.
  always_ff @(posedge xtal2) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      f_pend     <= 1'b0;
      f_addr_q   <= '0;
      d_pend     <= 1'b0;
      d_we_q     <= 1'b0;
      d_wide_q   <= 1'b0;
      d_addr_q   <= '0;
      d_wdata_q  <= '0;
      cur_data   <= 1'b0;
      cur_we     <= 1'b0;
      cur_wdata  <= '0;
      prio_data  <= 1'b0;
      fetch_ack  <= 1'b0;
      fetch_data <= '0;
      data_ack   <= 1'b0;
      data_rdata <= '0;
      busy       <= 1'b0;
      p0_out     <= '0;
      p0_oe      <= 1'b0;
      p2_out     <= '0;
      p2_oe      <= 1'b0;
      ale_o      <= 1'b0;
      psen_n     <= 1'b1;
      rd_n       <= 1'b1;
      wr_n       <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so a later
      // assignment in this block overrides an earlier one for the same edge.
      fetch_ack <= 1'b0;
      data_ack  <= 1'b0;

      if (f_new) begin
        f_pend   <= 1'b1;
        f_addr_q <= fetch_addr;
      end
      if (d_new) begin
        d_pend    <= 1'b1;
        d_we_q    <= data_we;
        d_wide_q  <= data_wide;
        d_addr_q  <= data_addr;
        d_wdata_q <= data_wdata;
      end

      if (start) begin
        if (pick_data) d_pend <= 1'b0;
        else           f_pend <= 1'b0;
        // The pointer only moves on a real tie, so the loser of one tie wins
        // the next one.
        if (tie) prio_data <= !pick_data;
        cur_data  <= pick_data;
        cur_we    <= sel_we;
        cur_wdata <= sel_wdata;
        state     <= S_ADDR;
        cnt       <= ALE_LD;
        busy      <= 1'b1;
        ale_o     <= 1'b1;
        psen_n    <= 1'b1;
        rd_n      <= 1'b1;
        wr_n      <= 1'b1;
        p0_oe     <= 1'b1;
        p0_out    <= sel_addr[7:0];
        p2_oe     <= sel_p2;
        p2_out    <= sel_addr[15:8];
      end else begin
        case (state)
          S_ADDR: begin
            if (cnt == '0) begin
              state <= S_LATCH;
              cnt   <= '0;
              ale_o <= 1'b0;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          S_LATCH: begin
            state <= S_STROBE;
            cnt   <= STB_LD;
            if (!cur_data) begin
              psen_n <= 1'b0;
              p0_oe  <= 1'b0;
            end else if (cur_we) begin
              wr_n   <= 1'b0;
              p0_out <= cur_wdata;
            end else begin
              rd_n  <= 1'b0;
              p0_oe <= 1'b0;
            end
          end
          S_STROBE: begin
            if (cnt == '0) begin
              state  <= S_HOLD;
              cnt    <= '0;
              psen_n <= 1'b1;
              rd_n   <= 1'b1;
              wr_n   <= 1'b1;
              if (!cur_data) begin
                fetch_data <= p0_in;
                fetch_ack  <= 1'b1;
              end else begin
                data_ack <= 1'b1;
                if (!cur_we) data_rdata <= p0_in;
              end
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          S_HOLD: begin
            state <= S_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            p0_oe <= 1'b0;
            p2_oe <= 1'b0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ext_bus_ctrl.sv
// Directed bench for ext_bus_ctrl: single fetch, wide write, narrow read,
// request drop, contention with round-robin, reset mid-access, and a
// minimum-parameter instance with a random strobe-exclusivity run.
module tb_ext_bus_ctrl;

  logic xtal2 = 1'b0;
  always #5 xtal2 = ~xtal2;

  logic        rst;
  logic        fetch_req, data_req, data_we, data_wide;
  logic [15:0] fetch_addr, data_addr;
  logic [7:0]  data_wdata, p0_in;
  logic        fetch_ack, data_ack, busy, p0_oe, p2_oe, ale_o, psen_n, rd_n, wr_n;
  logic [7:0]  fetch_data, data_rdata, p0_out, p2_out;

  logic        s_fetch_req, s_data_req, s_data_we, s_data_wide;
  logic [15:0] s_fetch_addr, s_data_addr;
  logic [7:0]  s_data_wdata, s_p0_in;
  logic        s_fetch_ack, s_data_ack, s_busy, s_p0_oe, s_p2_oe, s_ale, s_psen_n, s_rd_n, s_wr_n;
  logic [7:0]  s_fetch_data, s_data_rdata, s_p0_out, s_p2_out;

  ext_bus_ctrl #(.ALE_CYC(2), .STB_CYC(3)) dut (
    .xtal2(xtal2), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack), .fetch_data(fetch_data),
    .data_req(data_req), .data_we(data_we), .data_wide(data_wide), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_ack(data_ack), .data_rdata(data_rdata), .busy(busy),
    .p0_in(p0_in), .p0_out(p0_out), .p0_oe(p0_oe), .p2_out(p2_out), .p2_oe(p2_oe),
    .ale_o(ale_o), .psen_n(psen_n), .rd_n(rd_n), .wr_n(wr_n)
  );

  ext_bus_ctrl #(.ALE_CYC(1), .STB_CYC(1)) dut_min (
    .xtal2(xtal2), .rst(rst),
    .fetch_req(s_fetch_req), .fetch_addr(s_fetch_addr), .fetch_ack(s_fetch_ack), .fetch_data(s_fetch_data),
    .data_req(s_data_req), .data_we(s_data_we), .data_wide(s_data_wide), .data_addr(s_data_addr),
    .data_wdata(s_data_wdata), .data_ack(s_data_ack), .data_rdata(s_data_rdata), .busy(s_busy),
    .p0_in(s_p0_in), .p0_out(s_p0_out), .p0_oe(s_p0_oe), .p2_out(s_p2_out), .p2_oe(s_p2_oe),
    .ale_o(s_ale), .psen_n(s_psen_n), .rd_n(s_rd_n), .wr_n(s_wr_n)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge xtal2);
    #1;
  endtask

  // Per-cycle trace of the main instance, cycle 0 = first ADDR cycle.
  logic       tr_ale[16], tr_psen[16], tr_rd[16], tr_wr[16], tr_p0oe[16], tr_p2oe[16];
  logic       tr_fack[16], tr_dack[16], tr_busy[16];
  logic [7:0] tr_p0[16], tr_p2[16], tr_fdat[16], tr_ddat[16];

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      tr_ale[i]  = ale_o;   tr_psen[i] = psen_n;  tr_rd[i]   = rd_n;    tr_wr[i] = wr_n;
      tr_p0oe[i] = p0_oe;   tr_p2oe[i] = p2_oe;   tr_fack[i] = fetch_ack;
      tr_dack[i] = data_ack; tr_busy[i] = busy;   tr_p0[i]   = p0_out;  tr_p2[i] = p2_out;
      tr_fdat[i] = fetch_data; tr_ddat[i] = data_rdata;
      step();
    end
  endtask

  int nreq, cyc, nlow, acks;
  logic excl_ok;

  initial begin
    rst = 1'b1;
    fetch_req = 0; data_req = 0; data_we = 0; data_wide = 0;
    fetch_addr = '0; data_addr = '0; data_wdata = '0; p0_in = '0;
    s_fetch_req = 0; s_data_req = 0; s_data_we = 0; s_data_wide = 0;
    s_fetch_addr = '0; s_data_addr = '0; s_data_wdata = '0; s_p0_in = '0;
    step(); step(); step();

    // Reset values
    check("rst p0_oe", p0_oe, 0);   check("rst p2_oe", p2_oe, 0);
    check("rst ale", ale_o, 0);
    check("rst strobes", {psen_n, rd_n, wr_n}, 3'b111);
    check("rst p0_out", p0_out, 8'h00); check("rst p2_out", p2_out, 8'h00);
    check("rst fdata", fetch_data, 8'h00); check("rst rdata", data_rdata, 8'h00);
    check("rst busy", busy, 0);
    check("rst acks", {fetch_ack, data_ack}, 2'b00);
    rst = 1'b0;
    step();

    // Single fetch at 0x1234
    fetch_addr = 16'h1234; p0_in = 8'hA5; fetch_req = 1;
    step(); fetch_req = 0;
    capture(8);
    for (int c = 0; c < 7; c++) begin
      check($sformatf("f ale c%0d", c), tr_ale[c], c < 2);
      check($sformatf("f psen c%0d", c), tr_psen[c], !(c >= 3 && c <= 5));
      check($sformatf("f ack c%0d", c), tr_fack[c], c == 6);
      check($sformatf("f p0_oe c%0d", c), tr_p0oe[c], c <= 2);
      check($sformatf("f p2 c%0d", c), {tr_p2oe[c], tr_p2[c]}, {1'b1, 8'h12});
      check($sformatf("f rdwr c%0d", c), {tr_rd[c], tr_wr[c]}, 2'b11);
    end
    check("f p0 addr c0", tr_p0[0], 8'h34);
    check("f p0 addr c2", tr_p0[2], 8'h34);
    check("f data c6", tr_fdat[6], 8'hA5);
    check("f busy c0", tr_busy[0], 1);
    check("f busy c7", tr_busy[7], 0);
    check("f p2_oe c7", tr_p2oe[7], 0);

    // Wide write 0x8001 <- 0x3C
    data_we = 1; data_wide = 1; data_addr = 16'h8001; data_wdata = 8'h3C; data_req = 1;
    step(); data_req = 0;
    capture(8);
    for (int c = 0; c < 8; c++) begin
      check($sformatf("w wr c%0d", c), tr_wr[c], !(c >= 3 && c <= 5));
      check($sformatf("w rd/psen c%0d", c), {tr_rd[c], tr_psen[c]}, 2'b11);
      check($sformatf("w ack c%0d", c), tr_dack[c], c == 6);
    end
    for (int c = 3; c < 7; c++)
      check($sformatf("w p0 c%0d", c), {tr_p0oe[c], tr_p0[c]}, {1'b1, 8'h3C});
    check("w p0 addr c0", {tr_p0oe[0], tr_p0[0]}, {1'b1, 8'h01});
    check("w p2 c1", {tr_p2oe[1], tr_p2[1]}, {1'b1, 8'h80});

    // Narrow read 0x0055, bus returns 0x7E
    data_we = 0; data_wide = 0; data_addr = 16'h0055; p0_in = 8'h7E; data_req = 1;
    step(); data_req = 0;
    capture(8);
    for (int c = 0; c < 8; c++) begin
      check($sformatf("r p2_oe c%0d", c), tr_p2oe[c], 0);
      check($sformatf("r rd c%0d", c), tr_rd[c], !(c >= 3 && c <= 5));
      check($sformatf("r ack c%0d", c), tr_dack[c], c == 6);
    end
    check("r p0 addr c0", tr_p0[0], 8'h55);
    check("r p0_oe c4", tr_p0oe[4], 0);
    check("r rdata c6", tr_ddat[6], 8'h7E);

    // Repeat fetch_req while a fetch is in service is dropped
    fetch_addr = 16'h0100; fetch_req = 1;
    step(); fetch_req = 0;
    acks = 0;
    for (int c = 0; c < 10; c++) begin
      fetch_req = (c == 2);
      acks += int'(fetch_ack);
      step();
    end
    fetch_req = 0;
    check("drop acks", acks, 1);
    check("drop busy", busy, 0);

    // Contention after reset: fetch first, then data; repeat goes data first
    rst = 1; step(); rst = 0;
    p0_in = 8'hC3; fetch_addr = 16'h2211; data_addr = 16'h4433; data_we = 0; data_wide = 1;
    fetch_req = 1; data_req = 1;
    step(); fetch_req = 0; data_req = 0;
    capture(15);
    check("c1 fack c6", tr_fack[6], 1);   check("c1 dack c6", tr_dack[6], 0);
    check("c1 dack c13", tr_dack[13], 1); check("c1 fack c13", tr_fack[13], 0);
    check("c1 p0 c0", tr_p0[0], 8'h11);   check("c1 p0 c7", tr_p0[7], 8'h33);
    check("c1 ale c7", tr_ale[7], 1);     check("c1 psen c4", tr_psen[4], 0);
    check("c1 rd c11", tr_rd[11], 0);     check("c1 busy c10", tr_busy[10], 1);
    check("c1 busy c14", tr_busy[14], 0); check("c1 rdata c13", tr_ddat[13], 8'hC3);
    fetch_req = 1; data_req = 1;
    step(); fetch_req = 0; data_req = 0;
    capture(15);
    check("c2 dack c6", tr_dack[6], 1);   check("c2 fack c6", tr_fack[6], 0);
    check("c2 fack c13", tr_fack[13], 1); check("c2 p0 c0", tr_p0[0], 8'h33);
    check("c2 p0 c7", tr_p0[7], 8'h11);   check("c2 rd c3", tr_rd[3], 0);

    // Reset pulsed during STROBE of a read
    data_we = 0; data_wide = 0; data_addr = 16'h0066; p0_in = 8'h99; data_req = 1;
    step(); data_req = 0;
    step(); step(); step(); step();
    check("mr rd c4", rd_n, 0);
    rst = 1; step(); rst = 0;
    check("mr rd", rd_n, 1); check("mr p0_oe", p0_oe, 0); check("mr busy", busy, 0);
    check("mr p0_out", p0_out, 8'h00); check("mr rdata", data_rdata, 8'h00);
    acks = 0;
    for (int c = 0; c < 10; c++) begin
      acks += int'(data_ack);
      step();
    end
    check("mr no ack", acks, 0);
    fetch_addr = 16'h0ABC; p0_in = 8'h5A; fetch_req = 1;
    step(); fetch_req = 0;
    capture(8);
    check("mr f ack c6", tr_fack[6], 1);
    check("mr f data c6", tr_fdat[6], 8'h5A);
    check("mr f p2 c0", tr_p2[0], 8'h0A);

    // Minimum-parameter instance: ack on cycle 3
    s_fetch_addr = 16'hBEEF; s_p0_in = 8'h42; s_fetch_req = 1;
    step(); s_fetch_req = 0;
    check("min ale c0", s_ale, 1);  check("min p0 c0", s_p0_out, 8'hEF);
    step(); check("min latch c1", {s_ale, s_psen_n}, 2'b01);
    step(); check("min psen c2", s_psen_n, 0);
    step(); check("min ack c3", s_fetch_ack, 1); check("min data c3", s_fetch_data, 8'h42);
    step(); check("min idle c4", s_busy, 0);

    // Random traffic on the minimum instance with strobe exclusivity checked
    nreq = 0; cyc = 0;
    while (nreq < 1000 && cyc < 20000) begin
      s_fetch_req  = ($urandom_range(0, 2) == 0);
      s_data_req   = ($urandom_range(0, 2) == 0);
      s_fetch_addr = 16'($urandom);  s_data_addr = 16'($urandom);
      s_data_we    = 1'($urandom);   s_data_wide = 1'($urandom);
      s_data_wdata = 8'($urandom);   s_p0_in     = 8'($urandom);
      nreq += int'(s_fetch_req) + int'(s_data_req);
      step();
      cyc++;
      nlow    = int'(!s_psen_n) + int'(!s_rd_n) + int'(!s_wr_n);
      excl_ok = (nlow <= 1) && !(s_ale && nlow != 0);
      check("excl", excl_ok, 1);
    end
    s_fetch_req = 0; s_data_req = 0;
    cyc = 0;
    while (s_busy && cyc < 50) begin
      step();
      cyc++;
    end
    check("min drain", s_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
